// File: rtl/ntt_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pqc_ntt_pkg
//  Purpose  : Shared constants, operation encodings and sequencer state type
//             for the Dilithium NTT datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package pqc_ntt_pkg;

  localparam int          N     = 256;
  localparam int          LOG_N = 8;
  localparam int unsigned Q     = 32'd8380417;

  // Operation codes; the FBU mode input uses the same encoding
  localparam logic [1:0] OP_NTT  = 2'b00;
  localparam logic [1:0] OP_INTT = 2'b01;
  localparam logic [1:0] OP_BYP  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_delay_line
//  Purpose  : DEPTH x WIDTH shift register with synchronous active-low clear.
//             Used to align control with RAM read data and FBU results.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Advance one stage per clock; clear drops anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ntt_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_addr_gen
//  Purpose  : Walks the 256-coefficient polynomial through the NTT / INTT
//             layers (or a single bypass copy pass), one butterfly per cycle,
//             and produces the matching delayed write-back addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_addr_gen
  import pqc_ntt_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [8:0] tw_addr,
  output logic [1:0] bf_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int PIPE    = RD_LAT + BF_LAT;
  localparam int c_cnt_w = $clog2(PIPE + 1);

  state_t               r_state, w_next;
  logic [1:0]           r_op;
  logic [2:0]           r_stage;
  logic [6:0]           r_idx;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 r_rd_en, r_busy, r_done;
  logic [7:0]           r_rd_a, r_rd_b;
  logic [8:0]           r_tw;

  logic                 w_accept;
  logic [2:0]           w_last_stage;
  logic                 w_rd_en, w_busy, w_done;
  logic [7:0]           w_rd_a, w_rd_b;
  logic [8:0]           w_tw;
  logic [2:0]           w_sh;
  logic [7:0]           w_len;
  logic [6:0]           w_mask, w_grp, w_off;
  logic [7:0]           w_j;
  logic [1:0]           w_mode_rd;
  logic [16:0]          w_wr;

  // A start landing in the done cycle is dropped so back-to-back requests
  // see at least one genuine IDLE cycle.
  assign w_accept     = start && (op != OP_IDLE) && !r_done;
  assign w_last_stage = (r_op == OP_BYP) ? 3'd0 : 3'd7;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: if (r_idx == 7'd127) w_next = ST_DRAIN;
      ST_DRAIN: if (r_cnt == '0) w_next = (r_stage == w_last_stage) ? ST_FIN : ST_ISSUE;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operation latch, layer / butterfly / drain counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= OP_NTT;
      r_stage <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= op;
          r_stage <= '0;
          r_idx   <= '0;
        end
        ST_ISSUE: begin
          r_idx <= r_idx + 7'd1;
          if (r_idx == 7'd127) r_cnt <= c_cnt_w'(PIPE - 1);
        end
        ST_DRAIN: begin
          if (r_cnt == '0) r_stage <= r_stage + 3'd1;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Butterfly addressing: log2(len) shrinks per layer for NTT, grows for INTT
  always_comb begin
    w_sh   = (r_op == OP_INTT) ? r_stage : (3'd7 - r_stage);
    w_len  = 8'd1 << w_sh;
    w_mask = w_len[6:0] - 7'd1;  // len=128 wraps to an all-ones mask
    w_grp  = r_idx >> w_sh;
    w_off  = r_idx & w_mask;
    w_j    = (({1'b0, w_grp} << w_sh) << 1) | {1'b0, w_off};
  end

  // Read-side outputs for the current FSM state
  always_comb begin
    w_rd_en = (r_state == ST_ISSUE);
    w_busy  = (r_state != ST_IDLE);
    w_done  = (r_state == ST_FIN);
    w_rd_a  = '0;
    w_rd_b  = '0;
    w_tw    = '0;
    if (w_rd_en) begin
      if (r_op == OP_BYP) begin
        w_rd_a = {r_idx, 1'b0};
        w_rd_b = {r_idx, 1'b1};
      end else begin
        w_rd_a = w_j;
        w_rd_b = w_j + w_len;
        if (r_op == OP_INTT) w_tw = {1'b1, (8'hFF >> r_stage) - {1'b0, w_grp}};
        else                 w_tw = {1'b0, (8'd1 << r_stage) + {1'b0, w_grp}};
      end
    end
  end

  // Register read-side outputs so they change one cycle after the decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= w_rd_en;
      r_rd_a  <= w_rd_a;
      r_rd_b  <= w_rd_b;
      r_tw    <= w_tw;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // FBU mode follows the RAM data, idle code when no data is valid
  assign w_mode_rd = r_rd_en ? r_op : OP_IDLE;

  ntt_delay_line #(.DEPTH(RD_LAT), .WIDTH(2)) u_mode_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (w_mode_rd),
    .dout (bf_mode)
  );

  ntt_delay_line #(.DEPTH(PIPE), .WIDTH(17)) u_wr_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({r_rd_en, r_rd_a, r_rd_b}),
    .dout (w_wr)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign tw_addr   = r_tw;
  assign wr_en     = w_wr[16];
  assign wr_addr_a = w_wr[15:8];
  assign wr_addr_b = w_wr[7:0];

endmodule
`default_nettype wire

// File: tb/tb_ntt_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_addr_gen
//  Purpose  : Self-checking bench for ntt_addr_gen: closed-form reference
//             model of the whole output trace, vector table, corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_addr_gen;

  localparam int RD_LAT = 1;
  localparam int BF_LAT = 4;
  localparam int PIPE   = RD_LAT + BF_LAT;
  localparam int LAYER  = 128 + PIPE;
  localparam int MAXT   = 1100;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [1:0] op;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [8:0] tw_addr;
  logic [1:0] bf_mode;

  ntt_addr_gen #(.RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .bf_mode  (bf_mode),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] tw;
    logic [1:0] mode;
    logic       wr_en;
    logic [7:0] wa;
    logic [7:0] wb;
  } obs_t;

  typedef struct {
    int opv;
    int stage;
    int idx;
    int a;
    int b;
    int tw;
  } vec_t;

  obs_t tr   [0:MAXT];
  vec_t vtab [0:8];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy  = busy;
    o.done  = done;
    o.rd_en = rd_en;
    o.ra    = rd_addr_a;
    o.rb    = rd_addr_b;
    o.tw    = tw_addr;
    o.mode  = bf_mode;
    o.wr_en = wr_en;
    o.wa    = wr_addr_a;
    o.wb    = wr_addr_b;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Read issued at cycle t (t counted from the accepted start edge), from
  // the layer / butterfly formulas with plain integer arithmetic.
  function automatic void rd_model(input int opv, input int t, output bit en,
                                   output int a, output int b, output int tw);
    int nst, l, p, len, grp, off, j;
    en = 0; a = 0; b = 0; tw = 0;
    nst = (opv == 2) ? 1 : 8;
    if (t < 1) return;
    l = (t - 1) / LAYER;
    p = (t - 1) % LAYER;
    if (l >= nst || p >= 128) return;
    en = 1;
    if (opv == 2) begin
      a = 2 * p;
      b = 2 * p + 1;
    end else begin
      len = (opv == 0) ? (128 >> l) : (1 << l);
      grp = p / len;
      off = p % len;
      j   = 2 * len * grp + off;
      a   = j;
      b   = j + len;
      tw  = (opv == 0) ? ((1 << l) + grp) : (256 + (256 >> l) - 1 - grp);
    end
  endfunction

  function automatic obs_t model(input int opv, input int t);
    obs_t o;
    bit   en;
    int   a, b, tw, d;
    o      = '0;
    o.mode = 2'b11;
    d      = ((opv == 2) ? 1 : 8) * LAYER + 1;
    o.busy = (t >= 1 && t <= d);
    o.done = (t == d);
    rd_model(opv, t, en, a, b, tw);
    o.rd_en = en; o.ra = 8'(a); o.rb = 8'(b); o.tw = 9'(tw);
    rd_model(opv, t - RD_LAT, en, a, b, tw);
    if (en) o.mode = 2'(opv);
    rd_model(opv, t - PIPE, en, a, b, tw);
    o.wr_en = en; o.wa = 8'(a); o.wb = 8'(b);
    return o;
  endfunction

  // Full operation with random ignored starts while busy and a start in the done cycle
  task automatic do_op(input int opv);
    int d, tmax, first_done, wr_cnt, haz;
    d    = ((opv == 2) ? 1 : 8) * LAYER + 1;
    tmax = d + 6;
    start = 1'b1;
    op    = 2'(opv);
    for (int t = 0; t <= tmax; t++) begin
      @(posedge clk); #1;
      tr[t] = sample();
      if (t == d) begin
        start = 1'b1; op = 2'b00;
      end else if (t < d && $urandom_range(0, 15) == 0) begin
        start = 1'b1; op = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0; op = 2'($urandom_range(0, 3));
      end
    end
    start = 1'b0;

    for (int t = 1; t <= tmax; t++)
      check($sformatf("trace op%0d cyc%0d", opv, t), 64'(tr[t]), 64'(model(opv, t)));

    for (int k = 0; k < 9; k++) begin
      if (vtab[k].opv == opv) begin
        int t;
        t = 1 + vtab[k].stage * LAYER + vtab[k].idx;
        check($sformatf("vec%0d op%0d s%0d i%0d", k, opv, vtab[k].stage, vtab[k].idx),
              {tr[t].rd_en, tr[t].ra, tr[t].rb, tr[t].tw},
              {1'b1, 8'(vtab[k].a), 8'(vtab[k].b), 9'(vtab[k].tw)});
      end
    end

    first_done = -1;
    wr_cnt     = 0;
    haz        = 0;
    for (int t = 1; t <= tmax; t++) begin
      if (tr[t].done && first_done < 0) first_done = t;
      if (tr[t].wr_en) wr_cnt++;
      if (tr[t].rd_en) begin
        for (int u = t; u <= t + 4 && u <= tmax; u++) begin
          if (tr[u].wr_en && (tr[u].wa == tr[t].ra || tr[u].wa == tr[t].rb ||
                              tr[u].wb == tr[t].ra || tr[u].wb == tr[t].rb))
            haz++;
        end
      end
    end
    check($sformatf("done_cycle op%0d", opv), 64'(first_done), (opv == 2) ? 64'd134 : 64'd1065);
    check($sformatf("wr_count op%0d", opv), 64'(wr_cnt), (opv == 2) ? 64'd128 : 64'd1024);
    check($sformatf("raw_hazard op%0d", opv), 64'(haz), 64'd0);
  endtask

  task automatic idle_check(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      start = 1'($urandom_range(0, 1));
      op    = 2'b11;
      @(posedge clk); #1;
      check($sformatf("%s %0d", name, k), {busy, done, rd_en, wr_en, bf_mode}, 6'b000011);
    end
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vtab[0] = '{0, 0,   0,   0, 128,   1};
    vtab[1] = '{0, 0, 127, 127, 255,   1};
    vtab[2] = '{0, 7,   5,  10,  11, 133};
    vtab[3] = '{0, 3,  20,  36,  52,   9};
    vtab[4] = '{1, 0,   0,   0,   1, 511};
    vtab[5] = '{1, 7,   0,   0, 128, 257};
    vtab[6] = '{1, 2,   9,  17,  21, 317};
    vtab[7] = '{2, 0,   0,   0,   1,   0};
    vtab[8] = '{2, 0, 127, 254, 255,   0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'(sample()), 64'd0);
    rst_n = 1'b1;

    idle_check($urandom_range(3, 8), "idle_op11");
    do_op(0);
    do_op(1);
    do_op(2);
    for (int r = 0; r < 2; r++) do_op($urandom_range(0, 2));

    // Reset in the middle of an NTT
    start = 1'b1; op = 2'b00;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      tr[t] = sample();
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      if (t == 299) rst_n = 1'b0;
    end
    for (int t = 1; t < 300; t++)
      check($sformatf("pre_reset cyc%0d", t), 64'(tr[t]), 64'(model(0, t)));
    @(posedge clk); #1;
    check("reset_mid_all_zero", 64'(sample()), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset %0d", k), {busy, done, rd_en, wr_en}, 4'b0000);
    end
    do_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Sequencer directly upstream of the FBU butterfly wrapper.
- Walks the Dilithium polynomial (N=256, 32-bit words, q=8380417) through all 8 NTT or INTT layers, one butterfly per cycle.
- Drives the coefficient RAM read addresses, twiddle ROM index and butterfly mode.
- Delays the matching write-back addresses by the read-plus-FBU pipeline depth so results land in place.

Parameters:
- RD_LAT, 1, coefficient RAM and twiddle ROM read latency in cycles.
- BF_LAT, 4, FBU latency from a/b/w/mode in to c/d out.
- PIPE, RD_LAT+BF_LAT (local), read-issue to write-back distance.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- op  in  2  00 NTT, 01 INTT, 10 bypass copy, 11 idle (start ignored)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse at completion
- rd_en  out  1  read strobe to RAM and ROM
- rd_addr_a  out  8  upper butterfly operand address (j)
- rd_addr_b  out  8  lower butterfly operand address (j+len)
- tw_addr  out  9  twiddle ROM index; bit 8 = 1 selects the pre-negated INTT half
- bf_mode  out  2  to FBU mode, aligned with RAM data (delayed RD_LAT)
- wr_en  out  1  write-back strobe, rd_en delayed PIPE cycles
- wr_addr_a  out  8  write address for FBU c output
- wr_addr_b  out  8  write address for FBU d output

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM goes to IDLE; counters and all delay-line stages clear; every output is 0.
- Reset mid-operation: the pipeline is abandoned, wr_en is 0 from the next cycle on, and done is not pulsed.

FSM, states IDLE, ISSUE, DRAIN, FIN:
- IDLE: start=1 with op!=11 latches op and goes to ISSUE with stage=0, idx=0. Any other start is ignored.
- ISSUE: rd_en=1 every cycle and idx increments. At idx=127, go to DRAIN with cnt=PIPE-1.
- DRAIN: rd_en=0 for PIPE cycles, so the last write of a layer precedes the first read of the next layer (no RAW hazard).
  - Then stage increments and the FSM returns to ISSUE.
  - After the last stage (7 for NTT/INTT, 0 for bypass) it goes to FIN.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in ISSUE, DRAIN and FIN.

Address arithmetic (stage s in 0..7, idx i in 0..127):
- NTT: len = 128>>s.
- INTT: len = 1<<s.
- Common: grp = i>>log2(len), off = i&(len-1), j = 2*len*grp + off; rd_addr_a = j, rd_addr_b = j+len.
- NTT twiddle: tw_addr = {0, (1<<s)+grp}.
- INTT twiddle: tw_addr = {1, (256>>s)-1-grp}.
- Bypass: one pass only, rd_addr_a = 2i, rd_addr_b = 2i+1, tw_addr = 0, bf_mode = 10.
- All address math is 8-bit unsigned and never wraps inside a layer.

Mode and timing:
- bf_mode = 00 or 01 per latched op during valid data; 11 (idle) when no valid data.
- Read outputs are registered: rd_* changes one cycle after the FSM decision.
- Write-side signals are a PIPE-deep shift register of {rd_en, rd_addr_a, rd_addr_b}.

Timing, with start sampled at cycle 0:
- First rd_en at cycle 1.
- Final wr_en at cycle 8*(128+PIPE).
- done at cycle 8*(128+PIPE)+1, which is 1065 for defaults.
- Bypass: done at cycle 128+PIPE+1.
- A start asserted in the done cycle is ignored; the next start is accepted in the following IDLE cycle.

Out of scope: final n^-1 scaling for INTT (handled by the downstream scale pass).

Decomposition:
- Shared package pqc_ntt_pkg holds:
  - N=256, LOG_N=8, Q=8380417
  - op encodings OP_NTT/OP_INTT/OP_BYP/OP_IDLE, reused for FBU mode
  - FSM state enum
- One sub-module, ntt_delay_line: a parameterised DEPTH x WIDTH shift register with synchronous active-low clear, used for bf_mode (DEPTH=RD_LAT) and for the write address/enable (DEPTH=PIPE).

Test Plan:
- NTT, op=00, start pulse:
  - First issue: rd_addr_a=0, rd_addr_b=128, tw_addr=1.
  - idx 127: 127/255, tw=1.
  - Stage 7, i=5: 10/11, tw_addr=133.
  - done at cycle 1065.
- INTT, op=01:
  - Stage 0, i=0: 0/1, tw_addr=511.
  - Stage 7, i=0: 0/128, tw_addr=257.
  - wr_en exactly 1024 cycles total.
- Write alignment: every wr_addr_a/b equals the rd_addr_a/b issued 5 cycles earlier. No cycle has rd_en=1 while a write to the same address is pending.
- Bypass, op=10:
  - 128 reads: (0,1), (2,3) … (254,255).
  - bf_mode=10 on data cycles.
  - done at cycle 134.
- Ignored starts: op=11 start, or start while busy -> no rd_en, no change to timing.
- rst_n=0 at cycle 300 of an NTT:
  - Next cycle all outputs are 0 and busy=0.
  - No done pulse.
  - A fresh start then completes normally in 1065 cycles.
